pixel_dispatcher: RTL and testbench

PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

---
 rtl/pixel_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_pixel_dispatcher.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pixel_dispatcher.sv
// Frame-level pixel scheduler: snapshots the camera once per frame, hands out
// raster-order pixels to ray-marcher cores round-robin, then waits for all cores to go idle.
`ifndef DISPLAY_WIDTH
`define DISPLAY_WIDTH 320
`endif
`ifndef DISPLAY_HEIGHT
`define DISPLAY_HEIGHT 240
`endif
`ifndef H_BITS
`define H_BITS 9
`endif
`ifndef V_BITS
`define V_BITS 8
`endif

package pixel_dispatcher_pkg;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vec3;
endpackage

module pixel_dispatcher
  import pixel_dispatcher_pkg::*;
#(
  parameter int NUM_CORES      = 4,
  parameter int DISPLAY_WIDTH  = `DISPLAY_WIDTH,
  parameter int DISPLAY_HEIGHT = `DISPLAY_HEIGHT,
  parameter int H_BITS         = `H_BITS,
  parameter int V_BITS         = `V_BITS
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  vec3                  pos_in,
  input  vec3                  dir_in,
  input  logic [2:0]           fractal_sel_in,
  input  logic                 pause_in,
  input  logic [NUM_CORES-1:0] core_ready_in,
  input  logic [NUM_CORES-1:0] core_idle_in,
  output logic [NUM_CORES-1:0] grant_out,
  output logic [H_BITS-1:0]    hcount_out,
  output logic [V_BITS-1:0]    vcount_out,
  output vec3                  pos_out,
  output vec3                  dir_out,
  output logic [2:0]           fractal_sel_out,
  output logic                 frame_done_out,
  output logic [15:0]          frame_count_out
);

  localparam int PTR_W = $clog2(NUM_CORES);

  typedef enum logic [1:0] {
    S_LATCH    = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [H_BITS-1:0]  r_hcount;
  logic [V_BITS-1:0]  r_vcount;
  logic               r_drain_first;
  logic [15:0]        r_frame_count;
  vec3                r_pos;
  vec3                r_dir;
  logic [2:0]         r_fractal_sel;

  logic [PTR_W-1:0]     w_cand_idx [NUM_CORES];
  logic [NUM_CORES-1:0] w_ready_rot;
  logic [PTR_W-1:0]     w_sel;
  logic                 w_found;
  logic [NUM_CORES-1:0] w_grant;
  logic                 w_xfer;
  logic                 w_last_h;
  logic                 w_last_v;

  // Candidate k is the core k positions after the round-robin pointer.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_rot
    assign w_cand_idx[gi]  = PTR_W'((32'(r_rr_ptr) + gi) % NUM_CORES);
    assign w_ready_rot[gi] = core_ready_in[w_cand_idx[gi]];
  end

  always_comb begin
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_ready_rot[k]) begin
        w_sel   = w_cand_idx[k];
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant = '0;
    if (r_state == S_DISPATCH && !pause_in && w_found) begin
      w_grant[w_sel] = 1'b1;
    end
  end

  assign w_xfer   = |w_grant;
  assign w_last_h = (r_hcount == H_BITS'(DISPLAY_WIDTH - 1));
  assign w_last_v = (r_vcount == V_BITS'(DISPLAY_HEIGHT - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= S_LATCH;
      r_rr_ptr      <= '0;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_drain_first <= 1'b0;
      r_frame_count <= '0;
      r_pos         <= '0;
      r_dir         <= '0;
      r_fractal_sel <= '0;
    end else begin
      case (r_state)
        S_LATCH: begin
          r_pos         <= pos_in;
          r_dir         <= dir_in;
          r_fractal_sel <= fractal_sel_in;
          r_hcount      <= '0;
          r_vcount      <= '0;
          r_state       <= S_DISPATCH;
        end
        S_DISPATCH: begin
          if (w_xfer) begin
            r_rr_ptr <= PTR_W'((32'(w_sel) + 1) % NUM_CORES);
            if (w_last_h) begin
              // The final pixel leaves the counters parked at the last coordinate.
              if (w_last_v) begin
                r_state       <= S_DRAIN;
                r_drain_first <= 1'b1;
              end else begin
                r_hcount <= '0;
                r_vcount <= r_vcount + 1'b1;
              end
            end else begin
              r_hcount <= r_hcount + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // Idle flags can lag the last grant by a cycle, so the first check is skipped.
          if (r_drain_first) begin
            r_drain_first <= 1'b0;
          end else if (&core_idle_in) begin
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= S_LATCH;
          end
        end
        default: r_state <= S_LATCH;
      endcase
    end
  end

  assign grant_out       = w_grant;
  assign hcount_out      = r_hcount;
  assign vcount_out      = r_vcount;
  assign pos_out         = r_pos;
  assign dir_out         = r_dir;
  assign fractal_sel_out = r_fractal_sel;
  // Pulse coincides with the DRAIN cycle that sees every core idle.
  assign frame_done_out  = (r_state == S_DRAIN) && !r_drain_first && (&core_idle_in);
  assign frame_count_out = r_frame_count;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Directed bench for pixel_dispatcher on a 4x2 frame with four cores.
module tb_pixel_dispatcher;
  import pixel_dispatcher_pkg::*;

  localparam int NC = 4;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 3;
  localparam int VB = 2;

  logic          clk = 1'b0;
  logic          rst;
  vec3           pos_in, dir_in;
  logic [2:0]    fsel_in;
  logic          pause;
  logic [NC-1:0] ready, idle;
  logic [NC-1:0] grant;
  logic [HB-1:0] hcount;
  logic [VB-1:0] vcount;
  vec3           pos_out, dir_out;
  logic [2:0]    fsel_out;
  logic          frame_done;
  logic [15:0]   frame_count;

  int n_checks = 0;
  int n_pass   = 0;

  vec3 p1, p2, d1;

  always #5 clk = ~clk;

  pixel_dispatcher #(
    .NUM_CORES(NC), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB)
  ) dut (
    .clk_in(clk), .rst_in(rst), .pos_in(pos_in), .dir_in(dir_in),
    .fractal_sel_in(fsel_in), .pause_in(pause), .core_ready_in(ready),
    .core_idle_in(idle), .grant_out(grant), .hcount_out(hcount),
    .vcount_out(vcount), .pos_out(pos_out), .dir_out(dir_out),
    .fractal_sel_out(fsel_out), .frame_done_out(frame_done),
    .frame_count_out(frame_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    p1 = '{x: 16'sd100, y: -16'sd5, z: 16'sd7};
    p2 = '{x: 16'sd321, y: -16'sd5, z: 16'sd7};
    d1 = '{x: 16'sd0,   y: 16'sd1,  z: -16'sd1};
    rst = 1'b1; pos_in = p1; dir_in = d1; fsel_in = 3'd5; pause = 1'b0;
    ready = 4'b1111; idle = 4'b1111;
    tick; tick;

    // Reset state
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_h", 64'(hcount), 64'(0));
    check("rst_v", 64'(vcount), 64'(0));
    check("rst_fcnt", 64'(frame_count), 64'(0));
    check("rst_fdone", 64'(frame_done), 64'(0));
    check("rst_pos", 64'(pos_out), 64'(0));

    // Frame 1: everything ready and idle
    rst = 1'b0;
    settle;
    check("latch_grant", 64'(grant), 64'(0));
    tick;
    check("snap_pos", 64'(pos_out), 64'(p1));
    check("snap_dir", 64'(dir_out), 64'(d1));
    check("snap_fsel", 64'(fsel_out), 64'(5));
    for (int i = 0; i < W * H; i++) begin
      check($sformatf("f1_grant%0d", i), 64'(grant), 64'(1) << (i % NC));
      check($sformatf("f1_h%0d", i), 64'(hcount), 64'(i % W));
      check($sformatf("f1_v%0d", i), 64'(vcount), 64'(i / W));
      check($sformatf("f1_fd%0d", i), 64'(frame_done), 64'(0));
      $display("frame1 pixel (%0d,%0d) grant=%b", hcount, vcount, grant);
      tick;
    end
    check("drain1_grant", 64'(grant), 64'(0));
    check("drain1_fd_ignored", 64'(frame_done), 64'(0));
    tick;
    check("drain2_fd", 64'(frame_done), 64'(1));
    check("drain2_fcnt", 64'(frame_count), 64'(0));
    tick;
    check("latch2_fcnt", 64'(frame_count), 64'(1));
    check("latch2_fd", 64'(frame_done), 64'(0));
    check("latch2_grant", 64'(grant), 64'(0));
    tick;

    // Frame 2: only core 2 ready, camera moved mid-frame
    ready = 4'b0100; pos_in = p2;
    for (int i = 0; i < 3; i++) begin
      settle;
      check($sformatf("c2_grant%0d", i), 64'(grant), 64'(4'b0100));
      check($sformatf("c2_h%0d", i), 64'(hcount), 64'(i));
      check($sformatf("hold_pos%0d", i), 64'(pos_out), 64'(p1));
      $display("frame2 pixel (%0d,%0d) grant=%b", hcount, vcount, grant);
      tick;
    end
    ready = 4'b1001;
    settle;
    check("rr_after_c2", 64'(grant), 64'(4'b1000));
    check("rr_h3", 64'(hcount), 64'(3));
    $display("frame2 pixel (%0d,%0d) grant=%b", hcount, vcount, grant);
    tick;

    // Pause at pixel (0,1)
    ready = 4'b1111; pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle;
      check($sformatf("pause_grant%0d", i), 64'(grant), 64'(0));
      check($sformatf("pause_h%0d", i), 64'(hcount), 64'(0));
      check($sformatf("pause_v%0d", i), 64'(vcount), 64'(1));
      $display("paused cycle %0d at (%0d,%0d)", i, hcount, vcount);
      tick;
    end
    pause = 1'b0;
    idle  = 4'b1110;
    for (int i = 0; i < W; i++) begin
      settle;
      check($sformatf("resume_grant%0d", i), 64'(grant), 64'(1) << i);
      check($sformatf("resume_h%0d", i), 64'(hcount), 64'(i));
      check($sformatf("resume_v%0d", i), 64'(vcount), 64'(1));
      $display("frame2 pixel (%0d,%0d) grant=%b", hcount, vcount, grant);
      tick;
    end

    // Drain with one core still busy
    for (int i = 0; i < 4; i++) begin
      check($sformatf("busy_fd%0d", i), 64'(frame_done), 64'(0));
      check($sformatf("busy_grant%0d", i), 64'(grant), 64'(0));
      check($sformatf("busy_hv%0d", i), 64'({hcount, vcount}), 64'({3'd3, 2'd1}));
      tick;
    end
    idle = 4'b1111;
    settle;
    check("idle_fd", 64'(frame_done), 64'(1));
    $display("frame2 done pulse=%b", frame_done);
    tick;
    check("latch3_fcnt", 64'(frame_count), 64'(2));
    check("latch3_pos_old", 64'(pos_out), 64'(p1));
    tick;
    check("snap3_pos_new", 64'(pos_out), 64'(p2));

    // Frame 3: reset while pixel (2,1) is offered
    for (int i = 0; i < 6; i++) begin
      check($sformatf("f3_grant%0d", i), 64'(grant), 64'(1) << (i % NC));
      tick;
    end
    check("pre_rst_h", 64'(hcount), 64'(2));
    check("pre_rst_v", 64'(vcount), 64'(1));
    rst = 1'b1;
    tick;
    check("mid_rst_h", 64'(hcount), 64'(0));
    check("mid_rst_v", 64'(vcount), 64'(0));
    check("mid_rst_fcnt", 64'(frame_count), 64'(0));
    check("mid_rst_fd", 64'(frame_done), 64'(0));
    check("mid_rst_grant", 64'(grant), 64'(0));
    check("mid_rst_pos", 64'(pos_out), 64'(0));
    $display("reset mid-frame: (%0d,%0d) count=%0d", hcount, vcount, frame_count);
    rst = 1'b0;
    tick;
    check("restart_grant", 64'(grant), 64'(4'b0001));
    check("restart_pos", 64'(pos_out), 64'(p2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
